bp_watch_unit: RTL and testbench

//  Parametrised hardware breakpoint unit for the supervised Synapse316 pair, sitting between target debug_out/code_addr and the visor register file.

---
 rtl/bp_pkg.sv | 19 +
 rtl/bp_channel.sv | 61 ++++++
 rtl/bp_watch_unit.sv | 158 +++++++++++++++
 tb/tb_bp_watch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared encodings for the breakpoint watch unit: hit causes, config field selectors and FSM states.
package bp_pkg;

    localparam logic [1:0] BP_CAUSE_ADDR = 2'd0;
    localparam logic [1:0] BP_CAUSE_STEP = 2'd1;
    localparam logic [1:0] BP_CAUSE_PRG  = 2'd2;

    localparam logic [1:0] BP_FIELD_ADDR = 2'd0;
    localparam logic [1:0] BP_FIELD_MASK = 2'd1;
    localparam logic [1:0] BP_FIELD_IGN  = 2'd2;
    localparam logic [1:0] BP_FIELD_CTRL = 2'd3;

    typedef enum logic [1:0] {
        BP_IDLE    = 2'd0,
        BP_PENDING = 2'd1,
        BP_HIT     = 2'd2
    } bp_state_e;

endpackage

// File: rtl/bp_channel.sv
// One breakpoint channel: address/mask/enable/ignore-count storage, masked
// address comparator and readback of the selected field.
module bp_channel
    import bp_pkg::*;
#(
    parameter int AW = 16,
    parameter int CW = 8
) (
    input  logic          sysclk,
    input  logic          sysreset_n,
    input  logic          cfg_wr,
    input  logic [1:0]    cfg_field,
    input  logic [AW-1:0] cfg_data,
    input  logic          dec,
    input  logic [AW-1:0] tg_code_addr,
    output logic          match,
    output logic          ign_zero,
    output logic [AW-1:0] rdata
);

    logic [AW-1:0] addr_r;
    logic [AW-1:0] mask_r;
    logic [CW-1:0] ign_r;
    logic          en_r;

    // Configuration storage; a visor write always wins over the ignore decrement.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            addr_r <= '0;
            mask_r <= '0;
            ign_r  <= '0;
            en_r   <= 1'b0;
        end else if (cfg_wr) begin
            case (cfg_field)
                BP_FIELD_ADDR: addr_r <= cfg_data;
                BP_FIELD_MASK: mask_r <= cfg_data;
                BP_FIELD_IGN:  ign_r  <= cfg_data[CW-1:0];
                BP_FIELD_CTRL: en_r   <= cfg_data[0];
                default:       en_r   <= en_r;
            endcase
        end else if (dec && (ign_r != '0)) begin
            ign_r <= ign_r - CW'(1);
        end
    end

    assign match    = en_r && (((tg_code_addr ^ addr_r) & ~mask_r) == '0);
    assign ign_zero = (ign_r == '0);

    // Field readback mux; narrow fields are zero-extended.
    always_comb begin
        rdata = '0;
        case (cfg_field)
            BP_FIELD_ADDR: rdata = addr_r;
            BP_FIELD_MASK: rdata = mask_r;
            BP_FIELD_IGN:  rdata = AW'(ign_r);
            BP_FIELD_CTRL: rdata = AW'(en_r);
            default:       rdata = '0;
        endcase
    end

endmodule

// File: rtl/bp_watch_unit.sv
// Hardware breakpoint unit: NUM_BP masked address channels plus step and
// program-break sources, hit FSM aligned to ordinary assignment cycles, capture and hit count.
module bp_watch_unit
    import bp_pkg::*;
#(
    parameter int NUM_BP = 4,
    parameter int AW     = 16,
    parameter int CW     = 8,
    parameter int HCW    = 16,
    localparam int SW    = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic           sysclk,
    input  logic           sysreset_n,
    input  logic [AW-1:0]  tg_code_addr,
    input  logic           tg_enable_exec,
    input  logic           program_break,
    input  logic           step,
    input  logic           cfg_load,
    input  logic [SW-1:0]  cfg_sel,
    input  logic [1:0]     cfg_field,
    input  logic [AW-1:0]  cfg_data,
    output logic [AW-1:0]  cfg_rdata,
    input  logic           hit_clear,
    output logic           bp_hit,
    output logic [1:0]     hit_cause,
    output logic [SW-1:0]  hit_chan,
    output logic [AW-1:0]  hit_addr,
    output logic [HCW-1:0] hit_total
);

    bp_state_e      state_r;
    logic           bp_hit_r;
    logic [1:0]     hit_cause_r;
    logic [SW-1:0]  hit_chan_r;
    logic [AW-1:0]  hit_addr_r;
    logic [HCW-1:0] hit_total_r;

    logic [NUM_BP-1:0] match_s;
    logic [NUM_BP-1:0] ign_zero_s;
    logic [NUM_BP-1:0] dec_s;
    logic [AW-1:0]     ch_rdata_s [NUM_BP];

    logic           src_any_s;
    logic [1:0]     cause_s;
    logic [SW-1:0]  chan_s;
    logic           abort_s;
    logic           go_s;
    logic [1:0]     decide_cause_s;
    logic [SW-1:0]  decide_chan_s;
    logic           ign_blk_s;
    logic [HCW-1:0] total_inc_s;

    for (genvar i = 0; i < NUM_BP; i++) begin : g_ch
        bp_channel #(.AW(AW), .CW(CW)) u_ch (
            .sysclk       (sysclk),
            .sysreset_n   (sysreset_n),
            .cfg_wr       (cfg_load && (cfg_sel == SW'(i))),
            .cfg_field    (cfg_field),
            .cfg_data     (cfg_data),
            .dec          (dec_s[i]),
            .tg_code_addr (tg_code_addr),
            .match        (match_s[i]),
            .ign_zero     (ign_zero_s[i]),
            .rdata        (ch_rdata_s[i])
        );
    end

    // Source priority, ignore-counter gating of the hit decision and readback select.
    always_comb begin
        src_any_s = program_break || step || (match_s != '0);
        cause_s   = program_break ? BP_CAUSE_PRG : (step ? BP_CAUSE_STEP : BP_CAUSE_ADDR);
        chan_s    = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            chan_s = match_s[i] ? SW'(i) : chan_s;
        end

        abort_s = cfg_load || (hit_clear && (state_r != BP_HIT));
        go_s    = !abort_s && tg_enable_exec &&
                  (((state_r == BP_IDLE) && src_any_s) || (state_r == BP_PENDING));

        // A direct IDLE->HIT decision uses the live source, otherwise the captured one.
        decide_cause_s = (state_r == BP_IDLE) ? cause_s : hit_cause_r;
        decide_chan_s  = (state_r == BP_IDLE) ? chan_s  : hit_chan_r;

        ign_blk_s = 1'b0;
        cfg_rdata = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            ign_blk_s = (decide_chan_s == SW'(i)) ? !ign_zero_s[i] : ign_blk_s;
            cfg_rdata = (cfg_sel == SW'(i)) ? ch_rdata_s[i] : cfg_rdata;
        end
        ign_blk_s = ign_blk_s && (decide_cause_s == BP_CAUSE_ADDR);

        for (int i = 0; i < NUM_BP; i++) begin
            dec_s[i] = go_s && ign_blk_s && (decide_chan_s == SW'(i));
        end

        total_inc_s = (hit_total_r == '1) ? hit_total_r : hit_total_r + HCW'(1);
    end

    // Hit FSM with capture registers and saturating hit counter.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state_r     <= BP_IDLE;
            bp_hit_r    <= 1'b0;
            hit_cause_r <= 2'd0;
            hit_chan_r  <= '0;
            hit_addr_r  <= '0;
            hit_total_r <= '0;
        end else begin
            case (state_r)
                BP_IDLE: begin
                    if (abort_s) begin
                        state_r <= BP_IDLE;
                    end else if (src_any_s) begin
                        hit_cause_r <= cause_s;
                        hit_chan_r  <= chan_s;
                        hit_addr_r  <= tg_code_addr;
                        if (!tg_enable_exec) begin
                            state_r <= BP_PENDING;
                        end else if (ign_blk_s) begin
                            state_r <= BP_IDLE;
                        end else begin
                            state_r     <= BP_HIT;
                            bp_hit_r    <= 1'b1;
                            hit_total_r <= total_inc_s;
                        end
                    end
                end
                BP_PENDING: begin
                    if (abort_s || (tg_enable_exec && ign_blk_s)) begin
                        state_r <= BP_IDLE;
                    end else if (tg_enable_exec) begin
                        state_r     <= BP_HIT;
                        bp_hit_r    <= 1'b1;
                        hit_total_r <= total_inc_s;
                    end
                end
                BP_HIT: begin
                    if (hit_clear || cfg_load) begin
                        state_r  <= BP_IDLE;
                        bp_hit_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= BP_IDLE;
                    bp_hit_r <= 1'b0;
                end
            endcase
        end
    end

    assign bp_hit    = bp_hit_r;
    assign hit_cause = hit_cause_r;
    assign hit_chan  = hit_chan_r;
    assign hit_addr  = hit_addr_r;
    assign hit_total = hit_total_r;

endmodule

// File: tb/tb_bp_watch_unit.sv
// Directed bench for bp_watch_unit; a second instance with a 2-bit hit counter shares all inputs.
module tb_bp_watch_unit;
    import bp_pkg::*;

    logic        sysclk = 1'b0;
    logic        sysreset_n;
    logic [15:0] tg_code_addr;
    logic        tg_enable_exec;
    logic        program_break;
    logic        step;
    logic        cfg_load;
    logic [1:0]  cfg_sel;
    logic [1:0]  cfg_field;
    logic [15:0] cfg_data;
    logic        hit_clear;

    logic [15:0] cfg_rdata,  cfg_rdata2;
    logic        bp_hit,     bp_hit2;
    logic [1:0]  hit_cause,  hit_cause2;
    logic [1:0]  hit_chan,   hit_chan2;
    logic [15:0] hit_addr,   hit_addr2;
    logic [15:0] hit_total;
    logic [1:0]  hit_total2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 sysclk = ~sysclk;

    bp_watch_unit u_dut (
        .sysclk(sysclk), .sysreset_n(sysreset_n), .tg_code_addr(tg_code_addr),
        .tg_enable_exec(tg_enable_exec), .program_break(program_break), .step(step),
        .cfg_load(cfg_load), .cfg_sel(cfg_sel), .cfg_field(cfg_field), .cfg_data(cfg_data),
        .cfg_rdata(cfg_rdata), .hit_clear(hit_clear), .bp_hit(bp_hit), .hit_cause(hit_cause),
        .hit_chan(hit_chan), .hit_addr(hit_addr), .hit_total(hit_total)
    );

    bp_watch_unit #(.HCW(2)) u_dut2 (
        .sysclk(sysclk), .sysreset_n(sysreset_n), .tg_code_addr(tg_code_addr),
        .tg_enable_exec(tg_enable_exec), .program_break(program_break), .step(step),
        .cfg_load(cfg_load), .cfg_sel(cfg_sel), .cfg_field(cfg_field), .cfg_data(cfg_data),
        .cfg_rdata(cfg_rdata2), .hit_clear(hit_clear), .bp_hit(bp_hit2), .hit_cause(hit_cause2),
        .hit_chan(hit_chan2), .hit_addr(hit_addr2), .hit_total(hit_total2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge sysclk);
        #2;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [1:0] field, input logic [15:0] data);
        cfg_load  = 1'b1;
        cfg_sel   = sel;
        cfg_field = field;
        cfg_data  = data;
        tick();
        cfg_load  = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] sel, input logic [1:0] field,
                          input logic [15:0] exp);
        cfg_sel   = sel;
        cfg_field = field;
        #1;
        check(tag, 32'(cfg_rdata), 32'(exp));
    endtask

    task automatic release_hit();
        hit_clear      = 1'b1;
        tg_enable_exec = 1'b0;
        tg_code_addr   = 16'h1000;
        step           = 1'b0;
        program_break  = 1'b0;
        tick();
        hit_clear      = 1'b0;
    endtask

    initial begin
        int exp2 [4];
        exp2 = '{1, 2, 3, 3};
        sysreset_n     = 1'b0;
        tg_code_addr   = 16'h1000;
        tg_enable_exec = 1'b0;
        program_break  = 1'b0;
        step           = 1'b0;
        cfg_load       = 1'b0;
        cfg_sel        = 2'd0;
        cfg_field      = 2'd0;
        cfg_data       = 16'h0000;
        hit_clear      = 1'b0;
        repeat (2) @(posedge sysclk);
        #2;
        check("rst_bp_hit", 32'(bp_hit), 32'd0);
        check("rst_cause",  32'(hit_cause), 32'd0);
        check("rst_chan",   32'(hit_chan), 32'd0);
        check("rst_addr",   32'(hit_addr), 32'd0);
        check("rst_total",  32'(hit_total), 32'd0);
        chk_rd("rst_ctrl0", 2'd0, BP_FIELD_CTRL, 16'h0000);
        sysreset_n = 1'b1;
        tick();

        // 1: exact match, fetch then exec
        cfg_write(2'd0, BP_FIELD_ADDR, 16'h0040);
        cfg_write(2'd0, BP_FIELD_CTRL, 16'h0001);
        chk_rd("t1_rd_addr", 2'd0, BP_FIELD_ADDR, 16'h0040);
        chk_rd("t1_rd_ctrl", 2'd0, BP_FIELD_CTRL, 16'h0001);
        tg_code_addr = 16'h0040;
        tick();
        check("t1_pending_no_hit", 32'(bp_hit), 32'd0);
        tg_enable_exec = 1'b1;
        tg_code_addr   = 16'h0041;
        tick();
        check("t1_hit",   32'(bp_hit), 32'd1);
        check("t1_cause", 32'(hit_cause), 32'd0);
        check("t1_chan",  32'(hit_chan), 32'd0);
        check("t1_addr",  32'(hit_addr), 32'h0040);
        check("t1_total", 32'(hit_total), 32'd1);
        release_hit();
        check("t1_cleared", 32'(bp_hit), 32'd0);

        // 2: masked range match
        cfg_write(2'd1, BP_FIELD_ADDR, 16'h0100);
        cfg_write(2'd1, BP_FIELD_MASK, 16'h000F);
        cfg_write(2'd1, BP_FIELD_CTRL, 16'h0001);
        chk_rd("t2_rd_mask", 2'd1, BP_FIELD_MASK, 16'h000F);
        tg_code_addr   = 16'h010A;
        tg_enable_exec = 1'b1;
        tick();
        check("t2_hit",  32'(bp_hit), 32'd1);
        check("t2_chan", 32'(hit_chan), 32'd1);
        check("t2_addr", 32'(hit_addr), 32'h010A);
        release_hit();
        tg_code_addr   = 16'h0110;
        tg_enable_exec = 1'b1;
        repeat (2) tick();
        check("t2_outside_range", 32'(bp_hit), 32'd0);
        check("t2_total", 32'(hit_total), 32'd2);

        // 3: ignore counter passes twice then hits
        tg_enable_exec = 1'b0;
        tg_code_addr   = 16'h1000;
        cfg_write(2'd2, BP_FIELD_ADDR, 16'h0020);
        cfg_write(2'd2, BP_FIELD_IGN,  16'h0002);
        cfg_write(2'd2, BP_FIELD_CTRL, 16'h0001);
        chk_rd("t3_rd_ign2", 2'd2, BP_FIELD_IGN, 16'h0002);
        tg_code_addr = 16'h0020; tg_enable_exec = 1'b1; tick();
        check("t3_pass1_no_hit", 32'(bp_hit), 32'd0);
        chk_rd("t3_ign1", 2'd2, BP_FIELD_IGN, 16'h0001);
        tg_code_addr = 16'h1000; tick();
        tg_code_addr = 16'h0020; tick();
        check("t3_pass2_no_hit", 32'(bp_hit), 32'd0);
        chk_rd("t3_ign0", 2'd2, BP_FIELD_IGN, 16'h0000);
        tg_code_addr = 16'h1000; tick();
        tg_code_addr = 16'h0020; tick();
        check("t3_pass3_hit", 32'(bp_hit), 32'd1);
        check("t3_chan",  32'(hit_chan), 32'd2);
        check("t3_total", 32'(hit_total), 32'd3);
        release_hit();

        // 4: source priority
        cfg_write(2'd3, BP_FIELD_ADDR, 16'h0200);
        cfg_write(2'd3, BP_FIELD_CTRL, 16'h0001);
        cfg_write(2'd0, BP_FIELD_ADDR, 16'h0200);
        tg_code_addr = 16'h0200; step = 1'b1; tg_enable_exec = 1'b1; tick();
        check("t4_step_hit",   32'(bp_hit), 32'd1);
        check("t4_step_cause", 32'(hit_cause), 32'(BP_CAUSE_STEP));
        release_hit();
        tg_code_addr = 16'h0200; tg_enable_exec = 1'b1; tick();
        check("t4_addr_cause", 32'(hit_cause), 32'(BP_CAUSE_ADDR));
        check("t4_lowest_chan", 32'(hit_chan), 32'd0);
        release_hit();
        tg_code_addr = 16'h0200; step = 1'b1; program_break = 1'b1; tg_enable_exec = 1'b1; tick();
        check("t4_prg_cause", 32'(hit_cause), 32'(BP_CAUSE_PRG));
        check("t4_total", 32'(hit_total), 32'd6);
        release_hit();

        // 5: aborts from PENDING, then release from HIT
        cfg_write(2'd2, BP_FIELD_IGN, 16'h0001);
        tg_code_addr = 16'h0020; tick();
        cfg_load = 1'b1; cfg_sel = 2'd3; cfg_field = BP_FIELD_CTRL; cfg_data = 16'h0001;
        tg_enable_exec = 1'b1; tick();
        cfg_load = 1'b0; tg_code_addr = 16'h1000; tick();
        check("t5_cfg_abort_no_hit", 32'(bp_hit), 32'd0);
        chk_rd("t5_cfg_abort_ign", 2'd2, BP_FIELD_IGN, 16'h0001);
        tg_enable_exec = 1'b0; tg_code_addr = 16'h0020; tick();
        hit_clear = 1'b1; tg_enable_exec = 1'b1; tick();
        hit_clear = 1'b0; tg_code_addr = 16'h1000; tick();
        check("t5_clr_abort_no_hit", 32'(bp_hit), 32'd0);
        chk_rd("t5_clr_abort_ign", 2'd2, BP_FIELD_IGN, 16'h0001);
        tg_code_addr = 16'h0200; tick();
        check("t5_hit", 32'(bp_hit), 32'd1);
        check("t5_total", 32'(hit_total), 32'd7);
        release_hit();
        check("t5_hit_released", 32'(bp_hit), 32'd0);

        // 6: saturation on the 2-bit counter, then asynchronous reset mid-HIT
        sysreset_n = 1'b0;
        repeat (2) tick();
        check("t6_rst_total", 32'(hit_total), 32'd0);
        check("t6_rst_total2", 32'(hit_total2), 32'd0);
        sysreset_n = 1'b1;
        tick();
        cfg_write(2'd0, BP_FIELD_ADDR, 16'h0040);
        cfg_write(2'd0, BP_FIELD_CTRL, 16'h0001);
        for (int k = 0; k < 4; k++) begin
            tg_code_addr = 16'h0040; tg_enable_exec = 1'b1; tick();
            check("t6_hit2", 32'(bp_hit2), 32'd1);
            check("t6_total2", 32'(hit_total2), 32'(exp2[k]));
            release_hit();
        end
        check("t6_total_wide", 32'(hit_total), 32'd4);
        tg_code_addr = 16'h0040; program_break = 1'b1; tg_enable_exec = 1'b1; tick();
        check("t6_prg_hit", 32'(bp_hit), 32'd1);
        sysreset_n = 1'b0;
        #1;
        check("t6_async_bp_hit", 32'(bp_hit), 32'd0);
        check("t6_async_cause",  32'(hit_cause), 32'd0);
        check("t6_async_addr",   32'(hit_addr), 32'd0);
        check("t6_async_total",  32'(hit_total), 32'd0);
        check("t6_async_bp_hit2", 32'(bp_hit2), 32'd0);
        chk_rd("t6_async_cfg_lost", 2'd0, BP_FIELD_ADDR, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
